execute_vector_pipe: RTL and testbench

EXECUTE_VECTOR_PIPE -- requirements
Module: execute_vector_pipe

---
 rtl/execute_vector_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_execute_vector_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_vector_pipe.sv
// ============================================================================
// Module   : execute_vector_pipe
// Purpose  : Scalar/vector execute stage; scalar ops finish in one cycle, vector ops run LANES_PER_CYCLE lanes per beat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_vector_pipe #(
    parameter int VECTOR_DATA_WIDTH = 8,
    parameter int VECTOR_SIZE       = 6,
    parameter int LANES_PER_CYCLE   = 2,
    localparam int SCALAR_DATA_WIDTH = VECTOR_DATA_WIDTH * VECTOR_SIZE,
    localparam int BEATS             = VECTOR_SIZE / LANES_PER_CYCLE
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                flush,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [SCALAR_DATA_WIDTH-1:0]                        scalarData1,
    input  logic [SCALAR_DATA_WIDTH-1:0]                        scalarData2,
    input  logic [SCALAR_DATA_WIDTH-1:0]                        scalarInmediate,
    input  logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]       vectorOperand1,
    input  logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]       vectorOperand2,
    input  logic [2:0]                                          aluControl,
    input  logic                                                useInmediate,
    input  logic                                                isScalarInstruction,
    input  logic                                                writeScalar,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic [SCALAR_DATA_WIDTH-1:0]                        out,
    output logic [SCALAR_DATA_WIDTH-1:0]                        dataToWrite,
    output logic                                                N,
    output logic                                                Z,
    output logic                                                V,
    output logic                                                C
);

    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int MSB    = SCALAR_DATA_WIDTH - 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] VEC_RUN = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    function automatic logic [SCALAR_DATA_WIDTH-1:0] scalarOp(
        input logic [SCALAR_DATA_WIDTH-1:0] a,
        input logic [SCALAR_DATA_WIDTH-1:0] b,
        input logic [2:0]                   op
    );
        case (op)
            3'b000:  scalarOp = a + b;
            3'b001:  scalarOp = a - b;
            3'b010:  scalarOp = a & b;
            3'b011:  scalarOp = a | b;
            3'b100:  scalarOp = a ^ b;
            3'b101:  scalarOp = (a < b) ? a : b;
            3'b110:  scalarOp = (a > b) ? a : b;
            default: scalarOp = b;
        endcase
    endfunction

    function automatic logic [VECTOR_DATA_WIDTH-1:0] laneOp(
        input logic [VECTOR_DATA_WIDTH-1:0] a,
        input logic [VECTOR_DATA_WIDTH-1:0] b,
        input logic [2:0]                   op
    );
        case (op)
            3'b000:  laneOp = a + b;
            3'b001:  laneOp = a - b;
            3'b010:  laneOp = a & b;
            3'b011:  laneOp = a | b;
            3'b100:  laneOp = a ^ b;
            3'b101:  laneOp = (a < b) ? a : b;
            3'b110:  laneOp = (a > b) ? a : b;
            default: laneOp = b;
        endcase
    endfunction

    logic [1:0]                   r_state;
    logic [BEAT_W-1:0]            r_beat;
    logic [2:0]                   r_ctrl;
    logic [SCALAR_DATA_WIDTH-1:0] r_vecA;
    logic [SCALAR_DATA_WIDTH-1:0] r_vecB;
    logic [SCALAR_DATA_WIDTH-1:0] r_out;
    logic [SCALAR_DATA_WIDTH-1:0] r_dataToWrite;
    logic                         r_n;
    logic                         r_z;
    logic                         r_v;
    logic                         r_c;

    // Scalar path works straight from the ports so the result lands at the accept edge.
    logic [SCALAR_DATA_WIDTH-1:0] w_opB;
    logic [SCALAR_DATA_WIDTH-1:0] w_sRes;
    logic [SCALAR_DATA_WIDTH-1:0] w_sum;
    logic                         w_c;
    logic                         w_v;

    assign w_opB  = useInmediate ? scalarInmediate : scalarData2;
    assign w_sRes = scalarOp(scalarData1, w_opB, aluControl);
    assign w_sum  = scalarData1 + w_opB;

    always_comb begin
        w_c = 1'b0;
        w_v = 1'b0;
        if (aluControl == OP_ADD) begin
            w_c = (w_sum < scalarData1);
            w_v = (scalarData1[MSB] == w_opB[MSB]) && (w_sRes[MSB] != scalarData1[MSB]);
        end else if (aluControl == OP_SUB) begin
            w_c = (scalarData1 >= w_opB);
            w_v = (scalarData1[MSB] != w_opB[MSB]) && (w_sRes[MSB] != scalarData1[MSB]);
        end
    end

    logic [31:0]                  w_laneIdx [LANES_PER_CYCLE];
    logic [VECTOR_DATA_WIDTH-1:0] w_laneRes [LANES_PER_CYCLE];

    for (genvar j = 0; j < LANES_PER_CYCLE; j++) begin : g_lane
        assign w_laneIdx[j] = 32'(r_beat) * LANES_PER_CYCLE + j;
        assign w_laneRes[j] = laneOp(r_vecA[w_laneIdx[j]*VECTOR_DATA_WIDTH +: VECTOR_DATA_WIDTH],
                                     r_vecB[w_laneIdx[j]*VECTOR_DATA_WIDTH +: VECTOR_DATA_WIDTH],
                                     r_ctrl);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_beat        <= '0;
            r_ctrl        <= '0;
            r_vecA        <= '0;
            r_vecB        <= '0;
            r_out         <= '0;
            r_dataToWrite <= '0;
            r_n           <= 1'b0;
            r_z           <= 1'b0;
            r_v           <= 1'b0;
            r_c           <= 1'b0;
        end else if (flush) begin
            r_state <= IDLE;
            r_beat  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_ctrl        <= aluControl;
                        r_vecA        <= vectorOperand1;
                        r_vecB        <= vectorOperand2;
                        r_dataToWrite <= writeScalar ? w_opB : vectorOperand2;
                        r_beat        <= '0;
                        if (isScalarInstruction) begin
                            r_out   <= w_sRes;
                            r_n     <= w_sRes[MSB];
                            r_z     <= (w_sRes == '0);
                            r_v     <= w_v;
                            r_c     <= w_c;
                            r_state <= DONE;
                        end else begin
                            // Uncomputed lanes must read zero while the beats run.
                            r_out   <= '0;
                            r_state <= VEC_RUN;
                        end
                    end
                end
                VEC_RUN: begin
                    for (int j = 0; j < LANES_PER_CYCLE; j++) begin
                        r_out[w_laneIdx[j]*VECTOR_DATA_WIDTH +: VECTOR_DATA_WIDTH] <= w_laneRes[j];
                    end
                    if (r_beat == BEAT_W'(BEATS - 1)) begin
                        r_beat  <= '0;
                        r_state <= DONE;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_beat  <= '0;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign out         = r_out;
    assign dataToWrite = r_dataToWrite;
    assign N           = r_n;
    assign Z           = r_z;
    assign V           = r_v;
    assign C           = r_c;

endmodule

`default_nettype wire

// File: tb/tb_execute_vector_pipe.sv
// ============================================================================
// Module   : tb_execute_vector_pipe
// Purpose  : Directed self-checking bench for execute_vector_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_vector_pipe;

    localparam int VW = 8;
    localparam int VS = 6;
    localparam int SW = 48;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [SW-1:0]          scalarData1;
    logic [SW-1:0]          scalarData2;
    logic [SW-1:0]          scalarInmediate;
    logic [VS-1:0][VW-1:0]  vectorOperand1;
    logic [VS-1:0][VW-1:0]  vectorOperand2;
    logic [2:0]             aluControl;
    logic                   useInmediate;
    logic                   isScalarInstruction;
    logic                   writeScalar;
    logic                   out_valid;
    logic                   out_ready;
    logic [SW-1:0]          out;
    logic [SW-1:0]          dataToWrite;
    logic                   N;
    logic                   Z;
    logic                   V;
    logic                   C;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_vector_pipe #(
        .VECTOR_DATA_WIDTH(VW),
        .VECTOR_SIZE      (VS),
        .LANES_PER_CYCLE  (2)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush              (flush),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .scalarData1        (scalarData1),
        .scalarData2        (scalarData2),
        .scalarInmediate    (scalarInmediate),
        .vectorOperand1     (vectorOperand1),
        .vectorOperand2     (vectorOperand2),
        .aluControl         (aluControl),
        .useInmediate       (useInmediate),
        .isScalarInstruction(isScalarInstruction),
        .writeScalar        (writeScalar),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out                (out),
        .dataToWrite        (dataToWrite),
        .N                  (N),
        .Z                  (Z),
        .V                  (V),
        .C                  (C)
    );

    task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Flags packed as {N,Z,V,C}.
    task automatic checkFlags(input string tag, input logic [3:0] exp);
        check(tag, SW'({N, Z, V, C}), SW'(exp));
    endtask

    // Handshake packed as {out_valid,in_ready}.
    task automatic checkHs(input string tag, input logic [1:0] exp);
        check(tag, SW'({out_valid, in_ready}), SW'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        scalarData1 = '0; scalarData2 = '0; scalarInmediate = '0;
        vectorOperand1 = '0; vectorOperand2 = '0; aluControl = 3'b000;
        useInmediate = 1'b0; isScalarInstruction = 1'b0; writeScalar = 1'b0;
        step();
        step();
        check("reset_out", out, 48'h0);
        check("reset_dtw", dataToWrite, 48'h0);
        checkFlags("reset_flags", 4'b0000);
        checkHs("reset_hs", 2'b01);
        rst_n = 1'b1;
        step();
        checkHs("idle_hs", 2'b01);

        // Scalar ADD overflow into sign bit.
        scalarData1 = 48'h7FFF_FFFF_FFFF; scalarData2 = 48'h1; aluControl = 3'b000;
        isScalarInstruction = 1'b1; writeScalar = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checkHs("add_hs", 2'b10);
        check("add_out", out, 48'h8000_0000_0000);
        checkFlags("add_flags", 4'b1010);
        check("add_dtw", dataToWrite, 48'h1);
        consume();
        checkHs("add_release", 2'b01);

        // Scalar SUB with immediate, scalarData2 must be ignored.
        scalarData1 = 48'h5; scalarData2 = 48'h123; scalarInmediate = 48'h5;
        useInmediate = 1'b1; aluControl = 3'b001; in_valid = 1'b1;
        step();
        in_valid = 1'b0; useInmediate = 1'b0;
        checkHs("subimm_hs", 2'b10);
        check("subimm_out", out, 48'h0);
        checkFlags("subimm_flags", 4'b0101);
        check("subimm_dtw", dataToWrite, 48'h5);
        consume();

        // Vector ADD, every lane wraps to zero; flags must keep Z=1,C=1.
        for (int i = 0; i < VS; i++) begin
            vectorOperand1[i] = 8'hFF;
            vectorOperand2[i] = 8'h01;
        end
        aluControl = 3'b000; isScalarInstruction = 1'b0; writeScalar = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checkHs("vadd_t1", 2'b00);
        step();
        checkHs("vadd_t2", 2'b00);
        step();
        checkHs("vadd_t3", 2'b00);
        step();
        checkHs("vadd_t4", 2'b10);
        check("vadd_out", out, 48'h0);
        check("vadd_dtw", dataToWrite, 48'h0101_0101_0101);
        checkFlags("vadd_flags", 4'b0101);

        // Stall in DONE with a competing request that must not be accepted.
        scalarData1 = 48'hABC; scalarData2 = 48'h1; aluControl = 3'b000;
        isScalarInstruction = 1'b1; writeScalar = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checkHs("stall_hs", 2'b10);
            check("stall_out", out, 48'h0);
            check("stall_dtw", dataToWrite, 48'h0101_0101_0101);
        end
        in_valid = 1'b0;
        consume();
        checkHs("stall_release", 2'b01);
        check("stall_noaccept", out, 48'h0);

        // Vector XOR with distinct lanes to see beats fill in order.
        for (int i = 0; i < VS; i++) begin
            vectorOperand1[i] = 8'(8'h11 * (i + 1));
            vectorOperand2[i] = 8'h0F;
        end
        aluControl = 3'b100; isScalarInstruction = 1'b0; writeScalar = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("vxor_t1", out, 48'h0);
        step();
        check("vxor_t2", out, 48'h0000_0000_2D1E);
        step();
        check("vxor_t3", out, 48'h0000_4B3C_2D1E);
        step();
        checkHs("vxor_hs", 2'b10);
        check("vxor_out", out, 48'h695A_4B3C_2D1E);
        consume();

        // Vector unsigned MIN, store data taken from scalar B.
        for (int i = 0; i < VS; i++) begin
            vectorOperand1[i] = 8'h80;
            vectorOperand2[i] = 8'h7F;
        end
        scalarData2 = 48'hABC; aluControl = 3'b101; writeScalar = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        checkHs("vmin_hs", 2'b10);
        check("vmin_out", out, 48'h7F7F_7F7F_7F7F);
        check("vmin_dtw", dataToWrite, 48'hABC);
        consume();

        // Reset in cycle T+2 of a vector op.
        for (int i = 0; i < VS; i++) begin
            vectorOperand1[i] = 8'h01;
            vectorOperand2[i] = 8'h01;
        end
        aluControl = 3'b000; writeScalar = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("rstmid_partial", out, 48'h0000_0000_0202);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rstmid_out", out, 48'h0);
        check("rstmid_dtw", dataToWrite, 48'h0);
        checkFlags("rstmid_flags", 4'b0000);
        checkHs("rstmid_hs", 2'b01);

        // Flush in cycle T+1 of a vector op, then a scalar AND.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkHs("flush_hs", 2'b01);
        check("flush_out", out, 48'h0);
        scalarData1 = 48'hF0F0_F0F0_F0F0; scalarData2 = 48'hFF00_FF00_FF00;
        aluControl = 3'b010; isScalarInstruction = 1'b1; writeScalar = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checkHs("postflush_hs", 2'b10);
        check("postflush_out", out, 48'hF000_F000_F000);
        checkFlags("postflush_flags", 4'b1000);
        consume();

        // Flush beats a simultaneous request in IDLE.
        scalarData1 = 48'h1; scalarData2 = 48'h1; aluControl = 3'b000;
        flush = 1'b1; in_valid = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checkHs("flushwin_hs", 2'b01);
        check("flushwin_out", out, 48'hF000_F000_F000);

        // Scalar SUB 0-1: borrow clears C, negative result.
        scalarData1 = 48'h0; scalarData2 = 48'h1; aluControl = 3'b001; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("sub_borrow_out", out, 48'hFFFF_FFFF_FFFF);
        checkFlags("sub_borrow_flags", 4'b1000);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
